// File: rtl/pose_judge_pkg.sv
// Shared pose codes, judge FSM encodings and score helpers for pose_judge and the boss side.
package pose_judge_pkg;

  typedef logic [1:0] pose_t;
  typedef logic [2:0] judge_state_t;

  localparam pose_t POSE_UP      = 2'b11;
  localparam pose_t POSE_DOWN    = 2'b00;
  localparam pose_t POSE_LEFTUP  = 2'b10;
  localparam pose_t POSE_RIGHTUP = 2'b01;

  localparam judge_state_t ST_IDLE  = 3'd0;
  localparam judge_state_t ST_ARMED = 3'd1;
  localparam judge_state_t ST_HOLD  = 3'd2;
  localparam judge_state_t ST_HIT   = 3'd3;
  localparam judge_state_t ST_MISS  = 3'd4;
  localparam judge_state_t ST_OVER  = 3'd5;

  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
    logic [7:0] r;
    r = bcd;
    if (bcd == 8'h99) r = bcd;
    else if (bcd[3:0] == 4'd9) r = {bcd[7:4] + 4'd1, 4'd0};
    else r = {bcd[7:4], bcd[3:0] + 4'd1};
    return r;
  endfunction

  // Active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pose_judge_if.sv
// Boss <-> judge link: boss pose and round tick in, player pose and hit strobes back.
interface pose_judge_if;
  import pose_judge_pkg::*;

  pose_t boss_pose;
  logic  boss_tick;
  pose_t player_pose;
  logic  right;
  logic  hit_pulse;

  modport master (output boss_pose, output boss_tick,
                  input player_pose, input right, input hit_pulse);
  modport slave  (input boss_pose, input boss_tick,
                  output player_pose, output right, output hit_pulse);
endinterface

// File: rtl/pose_judge_switch_debounce.sv
// One-bit 2-flop synchronizer plus debounce; accepts a change after DEBOUNCE_CYC stable cycles.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC);

  logic            sync1_q, sync2_q, deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // For a single bit, any change of the synced value while counting returns it to deb_q,
  // so the equality test alone restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) deb_d = sync2_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb = deb_q;
endmodule

// File: rtl/pose_judge.sv
// Player pose judge: debounced switches vs boss pose per round, BCD score, misses, game over.
// Optional 7-segment score outputs when JUDGE_SEG_EN is defined.
module pose_judge
  import pose_judge_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned HOLD_CYC     = 1000,
  parameter int unsigned WINDOW_CYC   = 150000,
  parameter int unsigned MAX_MISS     = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sw_left,
  input  logic         sw_right,
  pose_judge_if.slave  bus,
  output logic [3:0]   score_ones,
  output logic [3:0]   score_tens,
  output logic [3:0]   miss_count,
  output logic         game_over
`ifdef JUDGE_SEG_EN
  ,
  output logic [6:0]   seg_ones,
  output logic [6:0]   seg_tens
`endif
);
  localparam int unsigned WinW  = $clog2(WINDOW_CYC);
  localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic left_deb, right_deb;
  pose_t player_pose;

  switch_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_left (
    .clk(clk), .reset(reset), .raw(sw_left), .deb(left_deb)
  );
  switch_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_right (
    .clk(clk), .reset(reset), .raw(sw_right), .deb(right_deb)
  );
  assign player_pose = {left_deb, right_deb};

  judge_state_t     state_q, state_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [HoldW:0]   hold_inc;
  logic             tick_q, right_q, right_d, hit_q, hit_d, over_q, over_d;
  logic [7:0]       score_q, score_d;
  logic [3:0]       miss_q, miss_d;
  logic             tick_rise, match, win_exp, do_hit, do_miss;

  assign tick_rise = bus.boss_tick & ~tick_q;
  assign match     = (player_pose == bus.boss_pose);
  assign win_exp   = (win_q == WinW'(WINDOW_CYC - 1));
  assign hold_inc  = (state_q == ST_HOLD) ? {1'b0, hold_q} + 1'b1 : (HoldW + 1)'(1);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    hold_d  = hold_q;
    right_d = right_q;
    over_d  = over_q;
    miss_d  = miss_q;
    score_d = score_q;
    hit_d   = 1'b0;
    do_hit  = 1'b0;
    do_miss = 1'b0;
    if (state_q != ST_OVER && miss_q == 4'(MAX_MISS)) begin
      state_d = ST_OVER;
      over_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (tick_rise) begin
          state_d = ST_ARMED;
          win_d   = '0;
          hold_d  = '0;
        end
        ST_ARMED, ST_HOLD: begin
          if (tick_rise) begin
            // Round outran the window: charge a miss and restart immediately.
            do_miss = 1'b1;
            state_d = ST_ARMED;
            win_d   = '0;
            hold_d  = '0;
          end else if (win_exp) begin
            do_miss = 1'b1;
            state_d = ST_MISS;
          end else begin
            win_d = win_q + 1'b1;
            if (!match) begin
              state_d = ST_ARMED;
              hold_d  = '0;
            end else if (hold_inc == (HoldW + 1)'(HOLD_CYC)) begin
              do_hit  = 1'b1;
              state_d = ST_HIT;
            end else begin
              state_d = ST_HOLD;
              hold_d  = hold_inc[HoldW-1:0];
            end
          end
        end
        ST_HIT, ST_MISS: if (tick_rise) begin
          right_d = 1'b0;
          state_d = ST_ARMED;
          win_d   = '0;
          hold_d  = '0;
        end
        ST_OVER: ;
        default: state_d = ST_IDLE;
      endcase
    end
    if (do_hit) begin
      hit_d   = 1'b1;
      right_d = 1'b1;
      score_d = bcd_inc(score_q);
    end
    if (do_miss) miss_d = miss_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      hold_q  <= '0;
      tick_q  <= 1'b0;
      right_q <= 1'b0;
      hit_q   <= 1'b0;
      over_q  <= 1'b0;
      score_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      tick_q  <= bus.boss_tick;
      right_q <= right_d;
      hit_q   <= hit_d;
      over_q  <= over_d;
      score_q <= score_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.player_pose = player_pose;
  assign bus.right       = right_q;
  assign bus.hit_pulse   = hit_q;
  assign score_ones      = score_q[3:0];
  assign score_tens      = score_q[7:4];
  assign miss_count      = miss_q;
  assign game_over       = over_q;

`ifdef JUDGE_SEG_EN
  logic [6:0] seg_ones_q, seg_tens_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_ones_q <= '0;
      seg_tens_q <= '0;
    end else begin
      seg_ones_q <= seg7(score_q[3:0]);
      seg_tens_q <= seg7(score_q[7:4]);
    end
  end

  assign seg_ones = seg_ones_q;
  assign seg_tens = seg_tens_q;
`endif
endmodule

// File: tb/tb_pose_judge.sv
// Directed self-checking bench for pose_judge with small debounce/hold/window/miss settings.
module tb_pose_judge;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sw_left = 1'b0;
  logic sw_right = 1'b0;
  logic [3:0] score_ones, score_tens, miss_count;
  logic game_over;
  int checks = 0;
  int passed = 0;

  pose_judge_if bus ();

`ifdef JUDGE_SEG_EN
  logic [6:0] seg_ones, seg_tens;
`endif

  pose_judge #(
    .DEBOUNCE_CYC(4), .HOLD_CYC(3), .WINDOW_CYC(20), .MAX_MISS(3)
  ) dut (
    .clk(clk), .reset(reset), .sw_left(sw_left), .sw_right(sw_right), .bus(bus),
    .score_ones(score_ones), .score_tens(score_tens), .miss_count(miss_count),
    .game_over(game_over)
`ifdef JUDGE_SEG_EN
    , .seg_ones(seg_ones), .seg_tens(seg_tens)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.boss_tick = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic set_sw(input logic l, input logic r);
    sw_left = l;
    sw_right = r;
    step(8);
  endtask

  task automatic pulse_tick();
    bus.boss_tick = 1'b1;
    step(1);
    bus.boss_tick = 1'b0;
  endtask

  task automatic test_reset();
    sw_left = 1'b0; sw_right = 1'b0; bus.boss_pose = 2'b00;
    apply_reset();
    step(1);
    checks++; if (bus.player_pose !== 2'b00) $display("FAIL reset_pose got %b exp 00", bus.player_pose); else passed++;
    checks++; if (bus.right !== 1'b0) $display("FAIL reset_right got %b exp 0", bus.right); else passed++;
    checks++; if (bus.hit_pulse !== 1'b0) $display("FAIL reset_hit got %b exp 0", bus.hit_pulse); else passed++;
    checks++; if ({score_tens, score_ones} !== 8'h00) $display("FAIL reset_score got %h exp 00", {score_tens, score_ones}); else passed++;
    checks++; if (miss_count !== 4'd0) $display("FAIL reset_miss got %0d exp 0", miss_count); else passed++;
    checks++; if (game_over !== 1'b0) $display("FAIL reset_over got %b exp 0", game_over); else passed++;
  endtask

  task automatic test_debounce();
    apply_reset();
    sw_left = 1'b1;
    step(2);
    sw_left = 1'b0;
    step(8);
    checks++; if (bus.player_pose !== 2'b00) $display("FAIL glitch_pose got %b exp 00", bus.player_pose); else passed++;
    sw_left = 1'b1;
    step(5);
    checks++; if (bus.player_pose !== 2'b00) $display("FAIL deb_early got %b exp 00", bus.player_pose); else passed++;
    step(1);
    checks++; if (bus.player_pose !== 2'b10) $display("FAIL deb_latency got %b exp 10", bus.player_pose); else passed++;
  endtask

  task automatic test_hit();
    apply_reset();
    bus.boss_pose = 2'b10;
    set_sw(1'b1, 1'b0);
    checks++; if (bus.player_pose !== 2'b10) $display("FAIL hit_pose got %b exp 10", bus.player_pose); else passed++;
    checks++; if (bus.hit_pulse !== 1'b0) $display("FAIL hit_pretick got %b exp 0", bus.hit_pulse); else passed++;
    pulse_tick();
    step(2);
    checks++; if (bus.hit_pulse !== 1'b0) $display("FAIL hit_early got %b exp 0", bus.hit_pulse); else passed++;
    step(1);
    checks++; if (bus.hit_pulse !== 1'b1) $display("FAIL hit_pulse got %b exp 1", bus.hit_pulse); else passed++;
    checks++; if (bus.right !== 1'b1) $display("FAIL hit_right got %b exp 1", bus.right); else passed++;
    checks++; if ({score_tens, score_ones} !== 8'h01) $display("FAIL hit_score got %h exp 01", {score_tens, score_ones}); else passed++;
    step(1);
    checks++; if (bus.hit_pulse !== 1'b0) $display("FAIL hit_one_cycle got %b exp 0", bus.hit_pulse); else passed++;
    checks++; if (bus.right !== 1'b1) $display("FAIL right_held got %b exp 1", bus.right); else passed++;
    pulse_tick();
    checks++; if (bus.right !== 1'b0) $display("FAIL right_drop got %b exp 0", bus.right); else passed++;
    bus.boss_pose = 2'b01;
  endtask

  task automatic test_broken_hold();
    apply_reset();
    bus.boss_pose = 2'b10;
    set_sw(1'b1, 1'b0);
    pulse_tick();
    step(2);
    bus.boss_pose = 2'b00;
    step(1);
    checks++; if (bus.hit_pulse !== 1'b0) $display("FAIL broken_drop got %b exp 0", bus.hit_pulse); else passed++;
    bus.boss_pose = 2'b10;
    step(2);
    checks++; if (bus.hit_pulse !== 1'b0) $display("FAIL broken_early got %b exp 0", bus.hit_pulse); else passed++;
    step(1);
    checks++; if (bus.hit_pulse !== 1'b1) $display("FAIL broken_hit got %b exp 1", bus.hit_pulse); else passed++;
    step(30);
    checks++; if ({score_tens, score_ones} !== 8'h01) $display("FAIL broken_score got %h exp 01", {score_tens, score_ones}); else passed++;
    checks++; if (miss_count !== 4'd0) $display("FAIL broken_miss got %0d exp 0", miss_count); else passed++;
  endtask

  task automatic test_expiry();
    apply_reset();
    bus.boss_pose = 2'b11;
    set_sw(1'b0, 1'b0);
    pulse_tick();
    step(19);
    checks++; if (miss_count !== 4'd0) $display("FAIL expiry_early got %0d exp 0", miss_count); else passed++;
    step(1);
    checks++; if (miss_count !== 4'd1) $display("FAIL expiry_miss got %0d exp 1", miss_count); else passed++;
    checks++; if (bus.right !== 1'b0) $display("FAIL expiry_right got %b exp 0", bus.right); else passed++;
  endtask

  task automatic test_early_tick();
    apply_reset();
    bus.boss_pose = 2'b11;
    set_sw(1'b0, 1'b0);
    pulse_tick();
    step(4);
    pulse_tick();
    checks++; if (miss_count !== 4'd1) $display("FAIL early_tick_miss got %0d exp 1", miss_count); else passed++;
  endtask

  task automatic test_game_over();
    apply_reset();
    bus.boss_pose = 2'b11;
    set_sw(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      step(22);
    end
    checks++; if (miss_count !== 4'd3) $display("FAIL over_miss got %0d exp 3", miss_count); else passed++;
    checks++; if (game_over !== 1'b1) $display("FAIL over_flag got %b exp 1", game_over); else passed++;
    bus.boss_pose = 2'b00;
    pulse_tick();
    step(6);
    checks++; if ({score_tens, score_ones} !== 8'h00) $display("FAIL over_score got %h exp 00", {score_tens, score_ones}); else passed++;
    checks++; if (bus.hit_pulse !== 1'b0 || bus.right !== 1'b0) $display("FAIL over_hit got %b%b exp 00", bus.hit_pulse, bus.right); else passed++;
    set_sw(1'b1, 1'b1);
    checks++; if (bus.player_pose !== 2'b11) $display("FAIL over_pose got %b exp 11", bus.player_pose); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (game_over !== 1'b0 || miss_count !== 4'd0) $display("FAIL over_reset got %b/%0d exp 0/0", game_over, miss_count); else passed++;
    checks++; if (bus.player_pose !== 2'b00) $display("FAIL over_reset_pose got %b exp 00", bus.player_pose); else passed++;
    step(1);
    reset = 1'b1;
  endtask

  task automatic test_saturation();
    apply_reset();
    bus.boss_pose = 2'b10;
    set_sw(1'b1, 1'b0);
    for (int i = 0; i < 99; i++) begin
      pulse_tick();
      step(4);
      if (i == 9) begin
        checks++; if ({score_tens, score_ones} !== 8'h10) $display("FAIL bcd_carry got %h exp 10", {score_tens, score_ones}); else passed++;
      end
    end
    checks++; if ({score_tens, score_ones} !== 8'h99) $display("FAIL sat_99 got %h exp 99", {score_tens, score_ones}); else passed++;
    pulse_tick();
    step(3);
    checks++; if (bus.hit_pulse !== 1'b1) $display("FAIL sat_pulse got %b exp 1", bus.hit_pulse); else passed++;
    checks++; if ({score_tens, score_ones} !== 8'h99) $display("FAIL sat_hold got %h exp 99", {score_tens, score_ones}); else passed++;
`ifdef JUDGE_SEG_EN
    step(1);
    checks++; if ({seg_tens, seg_ones} !== {7'b0010000, 7'b0010000}) $display("FAIL seg_99 got %b %b exp 0010000 0010000", seg_tens, seg_ones); else passed++;
`endif
  endtask

  initial begin
    bus.boss_pose = 2'b00;
    bus.boss_tick = 1'b0;
    test_reset();
    test_debounce();
    test_hit();
    test_broken_hold();
    test_expiry();
    test_early_tick();
    test_game_over();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
